// File: rtl/fft_pkg.sv
//------------------------------------------------------------------------------
// Module  : fft_pkg
// Brief   : Shared width defaults, FSM state encoding and bit-reverse helper
//           for the FFT RAM streaming blocks.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

    localparam int FFT_DATA_BIT_WIDTH = 32;
    localparam int FFT_ADDR_BIT_WIDTH = 16;
    localparam int FFT_LOG2_N         = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fft_state_e;

    // Reverses the low i_width bits of i_val; bits above i_width come back zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] i_val,
                                                input int unsigned i_width);
        logic [31:0] w_res;
        w_res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(i_width)) begin
                w_res[i] = i_val[int'(i_width) - 1 - i];
            end
        end
        return w_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_ram_reader_if.sv
//------------------------------------------------------------------------------
// Module  : fft_stream_if
// Brief   : Valid/ready output stream carrying FFT words with index/last tags.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fft_stream_if #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int LOG2_N         = 10
);
    logic [DATA_BIT_WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic [LOG2_N-1:0]         out_index;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_index,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/fft_skid_buf.sv
//------------------------------------------------------------------------------
// Module  : fft_skid_buf
// Brief   : 2-entry valid/ready FIFO with occupancy output for issue gating.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fft_skid_buf #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_pop,
    output logic [1:0]            o_count
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    assign o_valid = (r_count != 2'd0);
    assign o_pop   = o_valid && i_ready;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (o_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, o_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_ram_reader.sv
//------------------------------------------------------------------------------
// Module  : fft_ram_reader
// Brief   : Streams one 2^LOG2_N frame out of the FFT RAM read port onto a
//           valid/ready stream. Define BIT_REVERSE_EN for bit-reversed reads.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fft_ram_reader
    import fft_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = FFT_DATA_BIT_WIDTH,
    parameter int ADDR_BIT_WIDTH = FFT_ADDR_BIT_WIDTH,
    parameter int LOG2_N         = FFT_LOG2_N
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      start,
    input  wire logic [ADDR_BIT_WIDTH-1:0] base_addr,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_BIT_WIDTH-1:0]      read_addr,
    input  wire logic [DATA_BIT_WIDTH-1:0] ram_data,
    fft_stream_if.master                   out_if
);
    localparam logic [1:0]        S_IDLE     = ST_IDLE;
    localparam logic [1:0]        S_RUN      = ST_RUN;
    localparam logic [1:0]        S_DRAIN    = ST_DRAIN;
    localparam logic [LOG2_N-1:0] C_LAST_IDX = '1;
    localparam int                C_PAY_W    = DATA_BIT_WIDTH + LOG2_N + 1;

    logic [1:0]                r_state;
    logic [ADDR_BIT_WIDTH-1:0] r_base;
    logic [LOG2_N-1:0]         r_issue_cnt;
    logic [ADDR_BIT_WIDTH-1:0] r_read_addr;
    logic                      r_inflight;
    logic [LOG2_N-1:0]         r_inflight_idx;
    logic                      r_inflight_last;
    logic                      r_busy;
    logic                      r_done;

    logic [LOG2_N-1:0]  w_offset;
    logic [C_PAY_W-1:0] w_head;
    logic               w_valid;
    logic               w_pop;
    logic [1:0]         w_count;
    logic [2:0]         w_occ;
    logic               w_issue;
    logic               w_head_last;

`ifdef BIT_REVERSE_EN
    assign w_offset = LOG2_N'(bit_reverse(32'(r_issue_cnt), LOG2_N));
`else
    assign w_offset = r_issue_cnt;
`endif

    // Words buffered plus the one arriving this edge, net of the pop, must leave
    // room for the read issued now, so at most two words are ever held or in flight.
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == S_RUN) && (w_occ <= 3'd1);

    fft_skid_buf #(
        .WIDTH (C_PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  ({ram_data, r_inflight_idx, r_inflight_last}),
        .i_ready (out_if.out_ready),
        .o_valid (w_valid),
        .o_data  (w_head),
        .o_pop   (w_pop),
        .o_count (w_count)
    );

    assign w_head_last      = w_head[0];
    assign out_if.out_valid = w_valid;
    assign out_if.out_data  = w_head[C_PAY_W-1 -: DATA_BIT_WIDTH];
    assign out_if.out_index = w_head[LOG2_N:1];
    assign out_if.out_last  = w_head_last;

    assign busy      = r_busy;
    assign done      = r_done;
    assign read_addr = r_read_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_issue_cnt     <= '0;
            r_read_addr     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_idx  <= '0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_read_addr     <= r_base + ADDR_BIT_WIDTH'(w_offset);
                r_inflight_idx  <= r_issue_cnt;
                r_inflight_last <= (r_issue_cnt == C_LAST_IDX);
                r_issue_cnt     <= r_issue_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base      <= base_addr;
                        r_issue_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue && (r_issue_cnt == C_LAST_IDX)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Popping the tagged last word means every earlier word has left.
                    if (w_pop && w_head_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fft_ram_reader.md
Name: fft_ram_reader

Overview:
- Read-side streaming controller for the FFT dual-port RAM.
- On a start pulse, it issues 2^LOG2_N read addresses starting at a base address.
- It captures the RAM's read data, which arrives one cycle after the address, and presents the words on a valid/ready output stream with last/index tags.
- It sits between the RAM read port and the butterfly/output stage, and absorbs downstream backpressure without losing words.

Parameters:
- DATA_BIT_WIDTH, 32, RAM word width.
- ADDR_BIT_WIDTH, 16, RAM address width.
- LOG2_N, 10, log2 of frame length; legal range 1..ADDR_BIT_WIDTH.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to read one frame; sampled only in IDLE.
- base_addr  in  ADDR_BIT_WIDTH  frame base address; captured on an accepted start.
- busy  out  1  high from the accepted start until the last word is accepted.
- done  out  1  one-cycle pulse in the cycle after the last word handshake.
- read_addr  out  ADDR_BIT_WIDTH  to the RAM read address.
- ram_data  in  DATA_BIT_WIDTH  from the RAM data_out; valid one clk after read_addr is driven.
- out_data  out  DATA_BIT_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.
- out_last  out  1  high with the final word of the frame.
- out_index  out  LOG2_N  sequence index of out_data, 0..N-1.

Behaviour:
- Reset values:
  - busy=0, done=0, out_valid=0, out_last=0.
  - out_data=0, out_index=0, read_addr=0.
  - Issue counter, in-flight flag and buffer all cleared.
  - FSM enters IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches base_addr, clears counters, sets busy, and moves to RUN. start is ignored in every other state.
  - RUN: issues reads. After issuing index N-1, moves to DRAIN.
  - DRAIN: waits for the buffer to empty with the out_last word accepted, then pulses done and returns to IDLE.
- RAM timing:
  - read_addr driven from a register after posedge t yields valid ram_data at posedge t+1.
  - An in-flight flag, set when a read issues, causes ram_data to be written into the output buffer on the next posedge.
- Output buffer:
  - 2-entry FIFO (skid buffer).
  - A read issues in cycle t only if occupancy + inflight + (1 if a write is pending) <= 1 after accounting for a pop this cycle.
  - Net rule: never more than 2 words held or in flight.
  - Full throughput: 1 word/clk when out_ready is held high.
  - First out_valid appears 2 cycles after the accepted start.
- Handshake:
  - A word transfers when out_valid && out_ready.
  - While out_valid=1, out_data/out_index/out_last stay stable until accepted.
  - out_valid never drops without a transfer.
- Address rule: read_addr = (base + addr_offset(i)) mod 2^ADDR_BIT_WIDTH. Wrap-around past the top address is silent.
- Index tagging:
  - out_index = i, the natural sequence index, regardless of address order.
  - out_last = (i == N-1).
- Simultaneous events: a buffer push and pop in the same cycle keeps occupancy unchanged.
- rst mid-frame:
  - Aborts immediately with all state cleared.
  - No done pulse.
  - A RAM read already in flight is discarded.
- out_ready held low indefinitely: at most 2 reads are outstanding/buffered and issue stalls; no data loss and no duplication.

Optional Feature:
- Macro BIT_REVERSE_EN.
  - Defined: addr_offset(i) = bit-reverse of i over LOG2_N bits, so the frame is read in bit-reversed order for DIT output reordering.
  - Undefined: addr_offset(i) = i, a linear read.
- out_index is always the natural i in both builds.

Decomposition:
- Shared package fft_pkg holds:
  - default width constants (DATA_BIT_WIDTH, ADDR_BIT_WIDTH, LOG2_N);
  - FSM state enum (IDLE/RUN/DRAIN);
  - bit-reverse function.
- Natural sub-module fft_skid_buf: 2-entry valid/ready FIFO carrying {data, index, last}, with count output for issue gating.
- Address generation and FSM stay in the top module.

Test Plan:
- Linear frame: LOG2_N=3, base=0x0010, RAM[0x10+k]=k*3, out_ready=1, start pulse.
  - 8 words 0,3,...,21 on consecutive cycles.
  - First out_valid 2 clk after start; out_last with index 7.
  - done 1 clk after the last handshake.
- Bit-reversed build (BIT_REVERSE_EN defined): same setup.
  - Read addresses 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
  - Data 0,12,6,18,3,15,9,21; out_index 0..7 in order.
- Backpressure: out_ready toggled 1,0,0,1,0,1... pseudo-randomly.
  - Output sequence identical to the linear case; no gaps or duplicates; data stable while stalled.
  - read_addr advance never exceeds 2 words ahead of accepted words.
- Wrap: base=0xFFFE, LOG2_N=2.
  - Addresses 0xFFFE,0xFFFF,0x0000,0x0001; correct data.
- Start while busy: second start mid-frame with a different base.
  - Ignored; the frame completes from the original base; exactly one done.
- Reset mid-frame: rst asserted after 3 words accepted.
  - Next cycle busy=0, out_valid=0, no done.
  - A new start then produces a complete frame from index 0.
